// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use, branch-operand
// and HI/LO interlocks, memory wait-state holds and the mult/div busy sequencer.
module hazard_ctrl #(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       IMem_Wait,
    input  logic       DMem_Wait,
    input  logic [4:0] ID_Rs,
    input  logic [4:0] ID_Rt,
    input  logic       ID_UsesRs,
    input  logic       ID_UsesRt,
    input  logic       ID_IsBranch,
    input  logic       ID_ReadsHiLo,
    input  logic       ID_IsMultDiv,
    input  logic       ID_FlushReq,
    input  logic [4:0] EX_Rd,
    input  logic       EX_RegWrite,
    input  logic       EX_MemRead,
    input  logic       EX_MultStart,
    input  logic       EX_DivStart,
    input  logic [4:0] M_Rd,
    input  logic       M_MemRead,
    input  logic       Exc_Flush,
    output logic       IF_Stall,
    output logic       ID_Stall,
    output logic       EX_Stall,
    output logic       M_Stall,
    output logic       IF_Flush,
    output logic       ID_Flush,
    output logic       EX_Flush,
    output logic       MD_Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_match, m_match;
    logic load_use, br_haz, md_haz, any_haz;
    logic m_stall_raw, ex_stall_raw, id_stall_raw, if_stall_raw;
    logic md_busy_raw;

    // Register r0 never creates a dependency, and only sources actually read count.
    function automatic logic src_match(input logic uses, input logic [4:0] src,
                                       input logic [4:0] dst);
        return uses && (src != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        md_busy_raw  = (state_q == BUSY);
        ex_match     = src_match(ID_UsesRs, ID_Rs, EX_Rd) | src_match(ID_UsesRt, ID_Rt, EX_Rd);
        m_match      = src_match(ID_UsesRs, ID_Rs, M_Rd)  | src_match(ID_UsesRt, ID_Rt, M_Rd);
        load_use     = EX_MemRead & ex_match;
        br_haz       = ID_IsBranch & ((EX_RegWrite & ex_match) | (M_MemRead & m_match));
        md_haz       = md_busy_raw & (ID_ReadsHiLo | ID_IsMultDiv);
        any_haz      = load_use | br_haz | md_haz;
        m_stall_raw  = DMem_Wait;
        ex_stall_raw = m_stall_raw;
        id_stall_raw = ex_stall_raw | any_haz;
        if_stall_raw = id_stall_raw | IMem_Wait;
    end

    // Outputs read as zero for the whole time reset is asserted, not just after the edge.
    always_comb begin
        M_Stall  = ~RST & m_stall_raw;
        EX_Stall = ~RST & ex_stall_raw & ~Exc_Flush;
        ID_Stall = ~RST & id_stall_raw & ~Exc_Flush;
        IF_Stall = ~RST & if_stall_raw & ~Exc_Flush;
        IF_Flush = ~RST & (Exc_Flush | (ID_FlushReq & ~id_stall_raw));
        ID_Flush = ~RST & (Exc_Flush | (any_haz & ~ex_stall_raw));
        EX_Flush = ~RST & Exc_Flush;
        MD_Busy  = ~RST & md_busy_raw;
    end

    // Counter is loaded with N-1 and the unit stays BUSY through the cycle it reads 0,
    // giving exactly N busy cycles after the issue edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if ((EX_MultStart | EX_DivStart) & ~ex_stall_raw & ~Exc_Flush) begin
                    state_d = BUSY;
                    cnt_d   = EX_DivStart ? DIV_LOAD : MULT_LOAD;
                end
            end
            BUSY: begin
                if (Exc_Flush || cnt_q == '0) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stimulus pushes expected output vectors into a
// scoreboard queue, a monitor pops and compares them on the falling edge.
module tb_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       IMem_Wait, DMem_Wait;
    logic [4:0] ID_Rs, ID_Rt, EX_Rd, M_Rd;
    logic       ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_ReadsHiLo, ID_IsMultDiv, ID_FlushReq;
    logic       EX_RegWrite, EX_MemRead, EX_MultStart, EX_DivStart, M_MemRead, Exc_Flush;
    logic       IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush, EX_Flush, MD_Busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] v;
        string      nm;
    } exp_t;
    exp_t sb[$];

    // Expected vector order: {IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush, EX_Flush, MD_Busy}
    localparam logic [7:0] NONE   = 8'b0000_0000;
    localparam logic [7:0] HAZ    = 8'b1100_0100;
    localparam logic [7:0] ALLSTL = 8'b1111_0000;
    localparam logic [7:0] BUSY   = 8'b0000_0001;
    localparam logic [7:0] MDSTL  = 8'b1100_0101;
    localparam logic [7:0] EXC    = 8'b0000_1110;

    hazard_ctrl #(.MULT_CYCLES(4), .DIV_CYCLES(32), .CNT_W(6)) dut (
        .CLK(CLK), .RST(RST), .IMem_Wait(IMem_Wait), .DMem_Wait(DMem_Wait),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .ID_ReadsHiLo(ID_ReadsHiLo), .ID_IsMultDiv(ID_IsMultDiv),
        .ID_FlushReq(ID_FlushReq), .EX_Rd(EX_Rd), .EX_RegWrite(EX_RegWrite),
        .EX_MemRead(EX_MemRead), .EX_MultStart(EX_MultStart), .EX_DivStart(EX_DivStart),
        .M_Rd(M_Rd), .M_MemRead(M_MemRead), .Exc_Flush(Exc_Flush),
        .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Stall(EX_Stall), .M_Stall(M_Stall),
        .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .EX_Flush(EX_Flush), .MD_Busy(MD_Busy)
    );

    always #5 CLK = ~CLK;

    // Monitor: outputs are combinational, so each expectation is judged mid-cycle.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                exp_t       e;
                logic [7:0] act;
                e   = sb.pop_front();
                act = {IF_Stall, ID_Stall, EX_Stall, M_Stall, IF_Flush, ID_Flush, EX_Flush, MD_Busy};
                checks++;
                if (act !== e.v) begin
                    failures++;
                    $display("FAIL %s: got %b expected %b", e.nm, act, e.v);
                end else begin
                    $display("ok   %s: %b", e.nm, act);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] v);
        exp_t e;
        e.v  = v;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic clr_in();
        IMem_Wait = 0; DMem_Wait = 0; ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
        ID_IsBranch = 0; ID_ReadsHiLo = 0; ID_IsMultDiv = 0; ID_FlushReq = 0;
        EX_Rd = 0; EX_RegWrite = 0; EX_MemRead = 0; EX_MultStart = 0; EX_DivStart = 0;
        M_Rd = 0; M_MemRead = 0; Exc_Flush = 0;
    endtask

    task automatic set_load_use();
        EX_MemRead = 1; EX_Rd = 5; ID_Rs = 5; ID_UsesRs = 1;
    endtask

    initial begin : stim
        clr_in();
        // Reset forces outputs low even with DMem_Wait asserted
        tick(); DMem_Wait = 1; expect_out("reset_hold", NONE);
        tick(); RST = 0; clr_in(); expect_out("post_reset", NONE);

        // Load-use hazard and its non-hazard variants
        tick(); set_load_use(); expect_out("load_use", HAZ);
        tick(); clr_in(); expect_out("load_use_release", NONE);
        tick(); EX_MemRead = 1; EX_Rd = 0; ID_Rs = 0; ID_UsesRs = 1; expect_out("load_use_r0", NONE);
        tick(); clr_in(); EX_MemRead = 1; EX_Rd = 7; ID_Rt = 7; ID_UsesRt = 0; expect_out("load_use_unused_rt", NONE);

        // Branch operand hazard against EX then against a load in MEM
        tick(); clr_in(); ID_IsBranch = 1; ID_Rt = 9; ID_UsesRt = 1; EX_RegWrite = 1; EX_Rd = 9;
        expect_out("br_haz_ex", HAZ);
        tick(); EX_RegWrite = 0; EX_Rd = 0; M_MemRead = 1; M_Rd = 9; expect_out("br_haz_mem", HAZ);
        tick(); M_MemRead = 0; M_Rd = 0; expect_out("br_release", NONE);
        tick(); ID_IsBranch = 0; EX_RegWrite = 1; EX_Rd = 9; expect_out("regwrite_no_branch", NONE);

        // Data-memory wait during load-use: all hold, no bubble until the wait drops
        tick(); clr_in(); set_load_use(); DMem_Wait = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            expect_out($sformatf("dmem_wait_%0d", i), ALLSTL);
        end
        tick(); DMem_Wait = 0; expect_out("dmem_wait_drop", HAZ);
        tick(); clr_in(); expect_out("dmem_clear", NONE);

        // DIV issue followed by MFLO held for exactly 32 cycles
        tick(); EX_DivStart = 1; expect_out("div_issue", NONE);
        for (int i = 0; i < 32; i++) begin
            tick(); EX_DivStart = 0; ID_ReadsHiLo = 1;
            expect_out($sformatf("div_busy_%0d", i), MDSTL);
        end
        tick(); expect_out("mflo_advance", NONE);
        tick(); clr_in(); expect_out("div_done", NONE);

        // MULT: busy exactly 4 cycles, independent instructions not held
        tick(); EX_MultStart = 1; expect_out("mult_issue", NONE);
        for (int i = 0; i < 4; i++) begin
            tick(); EX_MultStart = 0;
            expect_out($sformatf("mult_busy_%0d", i), BUSY);
        end
        tick(); expect_out("mult_done", NONE);

        // Exception during MULT with counter at 2, IMem_Wait and HI/LO consumer pending
        tick(); EX_MultStart = 1; expect_out("mult2_issue", NONE);
        tick(); EX_MultStart = 0; expect_out("mult2_cnt3", BUSY);
        tick(); Exc_Flush = 1; IMem_Wait = 1; ID_ReadsHiLo = 1; expect_out("exc_in_mult", 8'b0000_1111);
        tick(); Exc_Flush = 0; IMem_Wait = 0; expect_out("exc_aborted", NONE);
        tick(); clr_in(); Exc_Flush = 1; DMem_Wait = 1; expect_out("exc_keeps_mstall", 8'b0001_1110);

        // Issue blocked by an exception or by an EX stall
        tick(); clr_in(); EX_MultStart = 1; Exc_Flush = 1; expect_out("start_vs_exc", EXC);
        tick(); clr_in(); expect_out("start_vs_exc_idle", NONE);
        tick(); EX_MultStart = 1; DMem_Wait = 1; expect_out("start_vs_stall", ALLSTL);
        tick(); clr_in(); expect_out("start_vs_stall_idle", NONE);

        // ID flush request is suppressed while ID holds
        tick(); set_load_use(); ID_FlushReq = 1; expect_out("flushreq_stalled", HAZ);
        tick(); clr_in(); ID_FlushReq = 1; expect_out("flushreq", 8'b0000_1000);

        // Asynchronous reset in the middle of a DIV (counter = 17)
        tick(); clr_in(); EX_DivStart = 1; expect_out("div2_issue", NONE);
        for (int i = 0; i < 14; i++) begin
            tick(); EX_DivStart = 0;
            expect_out($sformatf("div2_busy_%0d", i), BUSY);
        end
        tick(); ID_ReadsHiLo = 1; DMem_Wait = 1; expect_out("rst_mid_div", NONE);
        #2 RST = 1;
        tick(); RST = 0; clr_in(); ID_ReadsHiLo = 1; expect_out("after_rst", NONE);
        tick(); expect_out("after_rst_idle", NONE);
        tick(); clr_in(); EX_MultStart = 1; expect_out("mult3_issue", NONE);
        for (int i = 0; i < 4; i++) begin
            tick(); EX_MultStart = 0;
            expect_out($sformatf("mult3_busy_%0d", i), BUSY);
        end
        tick(); expect_out("mult3_done", NONE);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge CLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
